// File: rtl/fifo_slot_pkg.sv
// ---------------------------------------------------------------------------
// fifo_slot_pkg
// Definitions shared between the FIFO slot master and the slot responder.
//   fifo_slot_state_t : master FSM states
//   fifo_slot_dir_t   : arbitration direction (which side was served last)
//   SLOT_*            : register offsets within a slot register group
//   FULL_BIT/EMPTY_BIT: status bit positions in the offset-0 read data
//   slot_addr()       : builds the 5-bit slot address from group and offset
// ---------------------------------------------------------------------------
package fifo_slot_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_POLL = 3'd1,
        TX_WR   = 3'd2,
        RX_POLL = 3'd3,
        RX_POP  = 3'd4
    } fifo_slot_state_t;

    typedef enum logic {
        DIR_TX = 1'b0,
        DIR_RX = 1'b1
    } fifo_slot_dir_t;

    // Offset 0 is status/data and never pops; only a read of offset 2 pops.
    localparam logic [1:0] SLOT_STATUS = 2'b00;
    localparam logic [1:0] SLOT_WRITE  = 2'b01;
    localparam logic [1:0] SLOT_POP    = 2'b10;

    localparam int FULL_BIT  = 10;
    localparam int EMPTY_BIT = 9;

    function automatic logic [4:0] slot_addr(input logic [2:0] group,
                                             input logic [1:0] offset);
        return {group, offset};
    endfunction

endpackage

// File: rtl/fifo_slot_gap_cnt.sv
// ---------------------------------------------------------------------------
// fifo_slot_gap_cnt
// Loadable down-counter that spaces out retries of one direction after a
// poll found the slot FIFO full (TX) or empty (RX).
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   load        : load load_value this cycle (wins over decrement)
//   load_value  : retry gap in idle cycles
//   can_poll    : this direction may be selected this cycle
// The count decrements once per cycle while nonzero, whatever the FSM does.
// ---------------------------------------------------------------------------
module fifo_slot_gap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         can_poll
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // A count of 1 marks the last inserted idle cycle: selecting the
    // direction now puts the next poll in the cycle where the count has
    // reached zero, so exactly load_value idle cycles separate the polls.
    assign can_poll = (count <= W'(1));

endmodule

// File: rtl/fifo_slot_master.sv
// ---------------------------------------------------------------------------
// fifo_slot_master
// Bus initiator for one byte-FIFO slot. Turns a TX valid/ready byte stream
// into polled slot writes and drains the slot FIFO into an RX stream, so
// hardware can share the slot with the software driver.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   tx_data/tx_valid    : byte to push; must stay stable until tx_ready
//   tx_ready            : one-cycle pulse, tx_data written this cycle
//   rx_en               : allow draining of the slot FIFO
//   rx_data/rx_valid    : popped byte, held until rx_ready
//   rx_ready            : consumer takes rx_data
//   cs/read/write/addr  : slot access, one per cycle, decoded from the state
//   wr_data             : {24'h0, byte} during the write access, else 0
//   rd_data             : combinational slot read data
//   busy                : FSM not in IDLE
//   dbg_state           : current FSM state
//
// Handshakes: a byte moves on a stream when valid and ready are both high
// at a rising edge. tx_ready is only ever high in the write cycle and
// tx_valid/tx_data must not change from the poll to that write. rx_valid
// stays high with rx_data constant until rx_ready is seen.
// ---------------------------------------------------------------------------
module fifo_slot_master
    import fifo_slot_pkg::*;
#(
    parameter logic [2:0] PORT_OFS  = 3'b000,
    parameter int         RETRY_GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        rx_en,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        cs,
    output logic        read,
    output logic        write,
    output logic [4:0]  addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    localparam logic [3:0] GAP_LOAD = 4'(RETRY_GAP);

    fifo_slot_state_t state, next_state;
    fifo_slot_dir_t   last;

    logic tx_gap_load, rx_gap_load;
    logic tx_can_poll, rx_can_poll;
    logic tx_elig, rx_elig;
    logic capture;

    // Only the status bits and head byte of the read data matter here.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{rd_data[31:11], rd_data[8]};

    fifo_slot_gap_cnt #(.W(4)) u_tx_gap (
        .clk        (clk),
        .reset      (reset),
        .load       (tx_gap_load),
        .load_value (GAP_LOAD),
        .can_poll   (tx_can_poll)
    );

    fifo_slot_gap_cnt #(.W(4)) u_rx_gap (
        .clk        (clk),
        .reset      (reset),
        .load       (rx_gap_load),
        .load_value (GAP_LOAD),
        .can_poll   (rx_can_poll)
    );

    // A new RX poll is never started while the previous byte is unclaimed.
    assign tx_elig = tx_valid & tx_can_poll;
    assign rx_elig = rx_en & ~rx_valid & rx_can_poll;

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state  = state;
        tx_gap_load = 1'b0;
        rx_gap_load = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (tx_elig && rx_elig) begin
                    // Round-robin: the direction not served last wins.
                    next_state = (last == DIR_RX) ? TX_POLL : RX_POLL;
                end else if (tx_elig) begin
                    next_state = TX_POLL;
                end else if (rx_elig) begin
                    next_state = RX_POLL;
                end
            end
            TX_POLL: begin
                if (rd_data[FULL_BIT]) begin
                    next_state  = IDLE;
                    tx_gap_load = 1'b1;
                end else begin
                    next_state = TX_WR;
                end
            end
            TX_WR: begin
                next_state = IDLE;
            end
            RX_POLL: begin
                if (rd_data[EMPTY_BIT]) begin
                    next_state  = IDLE;
                    rx_gap_load = 1'b1;
                end else begin
                    next_state = RX_POP;
                    capture    = 1'b1;
                end
            end
            RX_POP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= DIR_RX;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == TX_POLL) begin
                last <= DIR_TX;
            end else if (state == IDLE && next_state == RX_POLL) begin
                last <= DIR_RX;
            end
            // The head byte is captured at the poll; it becomes visible only
            // once the pop has been issued, so a reset in between drops it
            // without ever removing it from the slot.
            if (capture) begin
                rx_data <= rd_data[7:0];
            end
            if (state == RX_POP) begin
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // ---------------- slot access decode ----------------
    always_comb begin
        cs       = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        tx_ready = 1'b0;
        addr     = 5'b0;
        wr_data  = 32'h0;
        case (state)
            TX_POLL, RX_POLL: begin
                cs   = 1'b1;
                read = 1'b1;
                addr = slot_addr(PORT_OFS, SLOT_STATUS);
            end
            TX_WR: begin
                cs       = 1'b1;
                write    = 1'b1;
                tx_ready = 1'b1;
                addr     = slot_addr(PORT_OFS, SLOT_WRITE);
                wr_data  = {24'h0, tx_data};
            end
            RX_POP: begin
                cs   = 1'b1;
                read = 1'b1;
                addr = slot_addr(PORT_OFS, SLOT_POP);
            end
            default: begin
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_fifo_slot_master.sv
module tb_fifo_slot_master;

  localparam int GAP = 4;
  localparam int SLAVE_DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        rx_en = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        cs, read, write, busy;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [2:0]  dbg_state;

  fifo_slot_master #(.PORT_OFS(3'b000), .RETRY_GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_en(rx_en), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- slot responder model ----------------
  logic [7:0] slave_mem [SLAVE_DEPTH];
  int slave_cnt = 0;
  int slave_rd = 0;
  int slave_wr = 0;
  logic force_full = 1'b0;
  logic force_empty = 1'b0;
  logic s_full, s_empty;

  assign s_full  = force_full || (slave_cnt == SLAVE_DEPTH);
  assign s_empty = force_empty || (slave_cnt == 0);
  assign rd_data = {21'h0, s_full, s_empty, 1'b0, slave_mem[slave_rd]};

  initial begin
    for (int i = 0; i < SLAVE_DEPTH; i++) slave_mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (cs && write && addr == 5'b00001 && slave_cnt < SLAVE_DEPTH) begin
      slave_mem[slave_wr] <= wr_data[7:0];
      slave_wr <= (slave_wr + 1) % SLAVE_DEPTH;
      slave_cnt <= slave_cnt + 1;
    end else if (cs && read && addr == 5'b00010 && slave_cnt > 0) begin
      slave_rd <= (slave_rd + 1) % SLAVE_DEPTH;
      slave_cnt <= slave_cnt - 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_hist[$];
  int txn_log[$];
  int stat_cyc[$];
  int n_wr = 0, n_pop = 0, n_stat = 0, n_rx = 0;
  logic acc_flag = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus/stream monitor: every accepted TX byte enters the expected queue,
  // every RX handshake must deliver the oldest byte still owed.
  logic prev_rv = 1'b0, prev_rr = 1'b0;
  logic [7:0] prev_rd = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      acc_flag = 1'b0;
      if (!reset) begin
        if (prev_rv && !prev_rr) begin
          check("rx_hold_valid", 32'(rx_valid), 32'd1);
          check("rx_hold_data", 32'(rx_data), 32'(prev_rd));
        end
        if (tx_ready) begin
          check("tx_write_access", {25'h0, cs, write, addr}, {25'h0, 1'b1, 1'b1, 5'b00001});
          check("tx_wr_data", wr_data, {24'h0, tx_data});
          exp_q.push_back(tx_data);
          n_wr++;
          txn_log.push_back(1);
          acc_flag = 1'b1;
        end else if (cs && write) begin
          check("write_without_tx_ready", 32'(tx_ready), 32'd1);
        end
        if (cs && read && addr[1:0] == 2'b10) begin
          check("pop_addr", 32'(addr), 32'h2);
          n_pop++;
          txn_log.push_back(2);
        end
        if (cs && read && addr[1:0] == 2'b00) begin
          n_stat++;
          stat_cyc.push_back(cyc);
        end
        if (rx_valid && rx_ready) begin
          check("rx_byte_owed", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
          n_rx++;
          rx_hist.push_back(rx_data);
        end
        prev_rv = rx_valid;
        prev_rr = rx_ready;
        prev_rd = rx_data;
      end else begin
        prev_rv = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit seen = 0;
    drv();
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx_ready) begin
        seen = 1;
        break;
      end
    end
    check("send_byte_accepted", 32'(seen), 32'd1);
    drv();
    tx_valid = 1'b0;
  endtask

  task automatic stop_tx();
    bit seen = 0;
    if (tx_valid) begin
      for (int i = 0; i < 120; i++) begin
        step();
        if (tx_ready) begin
          seen = 1;
          break;
        end
      end
      check("stop_tx_accepted", 32'(seen), 32'd1);
      drv();
      tx_valid = 1'b0;
    end
  endtask

  task automatic drain_all(input string tag);
    bit done = 0;
    drv();
    rx_en = 1'b1;
    rx_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (exp_q.size() == 0 && !rx_valid) begin
        done = 1;
        break;
      end
    end
    check(tag, 32'(done), 32'd1);
    check({tag, "_slave_empty"}, 32'(slave_cnt), 32'd0);
    drv();
    rx_en = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int p1, p2, w0, r0, pp, ss, sc, start, adj, writes;
    bit found;

    // Reset state
    repeat (3) drv();
    step();
    check("reset_strobes", {27'h0, cs, read, write, tx_ready, busy}, 32'h0);
    check("reset_addr", 32'(addr), 32'h0);
    check("reset_wr_data", wr_data, 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h0);

    // First TX byte: poll one cycle after leaving reset, write the next
    drv();
    reset = 1'b0;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    step();
    check("idle_after_reset", 32'(busy), 32'd0);
    step();
    check("tx_poll_access", {25'h0, cs, read, write, addr}, {25'h0, 1'b1, 1'b1, 1'b0, 5'b00000});
    step();
    check("tx_wr_access", {25'h0, cs, read, write, addr}, {25'h0, 1'b1, 1'b0, 1'b1, 5'b00001});
    check("tx_wr_value", wr_data, 32'h000000A5);
    check("tx_ready_pulse", 32'(tx_ready), 32'd1);
    drv();
    tx_valid = 1'b0;

    // Full on the first poll: retry after GAP idle cycles, one write only
    drv();
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    force_full = 1'b1;
    found = 0;
    p1 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cs && read && addr == 5'b00000) begin
        found = 1;
        p1 = cyc;
        break;
      end
    end
    check("full_first_poll_seen", 32'(found), 32'd1);
    w0 = n_wr;
    drv();
    force_full = 1'b0;
    found = 0;
    p2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (cs && read && addr == 5'b00000) begin
        found = 1;
        p2 = cyc;
        break;
      end
      step();
    end
    check("full_retry_seen", 32'(found), 32'd1);
    check("full_retry_spacing", 32'(p2 - p1), 32'(GAP + 1));
    check("full_no_write", 32'(n_wr), 32'(w0));
    step();
    check("full_retry_write", {23'h0, write, wr_data[7:0]}, {23'h0, 1'b1, 8'h5A});
    check("full_write_once", 32'(n_wr), 32'(w0 + 1));
    drv();
    tx_valid = 1'b0;

    // RX drain: slot holds A5, 5A, 11, 22
    send_byte(8'h11);
    send_byte(8'h22);
    r0 = n_rx;
    pp = n_pop;
    drv();
    rx_en = 1'b1;
    rx_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_rx == r0 + 4) begin
        found = 1;
        break;
      end
    end
    check("rx_drain_done", 32'(found), 32'd1);
    check("rx_pop_count", 32'(n_pop - pp), 32'd4);
    if (rx_hist.size() >= 2) begin
      check("rx_seq_11", 32'(rx_hist[rx_hist.size() - 2]), 32'h11);
      check("rx_seq_22", 32'(rx_hist[rx_hist.size() - 1]), 32'h22);
    end
    // Empty: status polls repeat every GAP+1 cycles without pops
    stat_cyc.delete();
    pp = n_pop;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (stat_cyc.size() >= 3) begin
        found = 1;
        break;
      end
    end
    check("empty_polls_seen", 32'(found), 32'd1);
    if (stat_cyc.size() >= 3) begin
      check("empty_spacing_1", 32'(stat_cyc[1] - stat_cyc[0]), 32'(GAP + 1));
      check("empty_spacing_2", 32'(stat_cyc[2] - stat_cyc[1]), 32'(GAP + 1));
    end
    check("empty_no_pop", 32'(n_pop), 32'(pp));
    drv();
    rx_en = 1'b0;

    // Both directions eligible: accesses must alternate
    send_byte(8'($urandom));
    drv();
    rx_en = 1'b1;
    rx_ready = 1'b1;
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    start = txn_log.size();
    for (int i = 0; i < 400; i++) begin
      step();
      if (tx_ready) begin
        drv();
        tx_data = 8'($urandom);
      end
      if (txn_log.size() - start >= 20) break;
    end
    stop_tx();
    check("rr_txn_count", 32'(txn_log.size() - start >= 20), 32'd1);
    adj = 0;
    writes = 0;
    if (txn_log.size() - start >= 20) begin
      for (int i = start; i < start + 20; i++) begin
        if (txn_log[i] == 1) writes++;
        if (i > start && txn_log[i] == txn_log[i - 1]) adj++;
      end
    end
    check("rr_alternate", 32'(adj), 32'd0);
    check("rr_writes_eq_pops", 32'(writes), 32'd10);

    // Random traffic against the FIFO reference
    for (int i = 0; i < 600; i++) begin
      drv();
      if (!tx_valid || acc_flag) begin
        tx_valid = ($urandom_range(0, 2) != 0);
        tx_data = 8'($urandom);
      end
      rx_ready = 1'($urandom_range(0, 1));
      rx_en = ($urandom_range(0, 3) != 0);
      force_full = ($urandom_range(0, 5) == 0);
      force_empty = ($urandom_range(0, 5) == 0);
    end
    drv();
    force_full = 1'b0;
    force_empty = 1'b0;
    stop_tx();
    drain_all("random_drain");

    // Consumer stalled on 33: no further RX polls, TX keeps going
    send_byte(8'h33);
    send_byte(8'h44);
    drv();
    rx_en = 1'b1;
    rx_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rx_valid) begin
        found = 1;
        break;
      end
    end
    check("stall_rx_valid", 32'(found), 32'd1);
    check("stall_rx_data", 32'(rx_data), 32'h33);
    pp = n_pop;
    ss = n_stat;
    w0 = n_wr;
    send_byte(8'h55);
    repeat (15) step();
    check("stall_no_pop", 32'(n_pop), 32'(pp));
    check("stall_only_tx_poll", 32'(n_stat - ss), 32'd1);
    check("stall_tx_continues", 32'(n_wr - w0), 32'd1);
    check("stall_hold", {23'h0, rx_valid, rx_data}, {23'h0, 1'b1, 8'h33});
    drv();
    rx_en = 1'b0;
    rx_ready = 1'b1;
    drv();
    rx_ready = 1'b0;

    // Reset during RX_POLL with data present: no pop, byte stays in slot
    drv();
    rx_en = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cs && read && addr == 5'b00000) begin
        reset = 1'b1;
        found = 1;
        break;
      end
    end
    check("rst_poll_seen", 32'(found), 32'd1);
    sc = slave_cnt;
    pp = n_pop;
    step();
    check("rst_strobes", {27'h0, cs, read, write, tx_ready, busy}, 32'h0);
    check("rst_addr_data", {3'h0, addr, wr_data[23:0]}, 32'h0);
    check("rst_rx", {23'h0, rx_valid, rx_data}, 32'h0);
    check("rst_slave_unchanged", 32'(slave_cnt), 32'd2);
    check("rst_slave_same", 32'(slave_cnt), 32'(sc));
    drv();
    reset = 1'b0;
    step();
    check("rst_no_pop", 32'(n_pop), 32'(pp));
    drain_all("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
